// File: rtl/mem_access_pkg.sv
// Shared load/store encodings: funct3 size codes, FSM states, byte-enable patterns
// and the small helpers that turn an access into lanes or a fault decision.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    // Unsigned sizes are load-only; a simultaneous load and store is never legal.
    function automatic logic access_fault(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = lo[0];
            F3_W:    bad = |lo;
            F3_BU:   bad = wr;
            F3_HU:   bad = wr | lo[0];
            default: bad = 1'b1;
        endcase
        return bad | (rd & wr);
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B:    return 4'b0001 << lo;
            F3_H:    return lo[1] ? BE_HI : BE_LO;
            default: return BE_ALL;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3)
            F3_B:    return {4{rs2[7:0]}};
            F3_H:    return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: IDLE -> REQ (ready handshake, timeout) -> RESP (Done pulse).
// Illegal or misaligned accesses skip the memory and complete with Fault from IDLE.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData2,
    output logic        Stall,
    output logic        Done,
    output logic        Fault,
    output logic [31:0] LoadData,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemBe,
    input  logic        MemReady,
    input  logic [31:0] MemRData
);

    logic [1:0]  state_reg;
    logic [15:0] wait_reg;
    logic [31:0] addr_reg;
    logic [1:0]  addr_lo_reg;
    logic [2:0]  f3_reg;
    logic        we_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;
    logic        fault_reg;
    logic [31:0] load_data_reg;

    logic        access;
    logic        bad;
    logic [15:0] wait_inc;
    logic        wait_hit;
    logic [31:0] ext_data;

    assign access   = MemRead | MemWrite;
    assign bad      = access_fault(MemRead, MemWrite, funct3, ALUResult[1:0]);
    assign wait_inc = (wait_reg == 16'hFFFF) ? wait_reg : wait_reg + 16'd1;
    assign wait_hit = ({16'd0, wait_inc} >= TIMEOUT);

    load_extend u_load_extend (
        .rdata   (MemRData),
        .addr_lo (addr_lo_reg),
        .funct3  (f3_reg),
        .data    (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            wait_reg      <= '0;
            addr_reg      <= '0;
            addr_lo_reg   <= '0;
            f3_reg        <= '0;
            we_reg        <= 1'b0;
            be_reg        <= BE_NONE;
            wdata_reg     <= '0;
            fault_reg     <= 1'b0;
            load_data_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (access) begin
                        if (bad) begin
                            state_reg     <= S_RESP;
                            fault_reg     <= 1'b1;
                            load_data_reg <= '0;
                        end else begin
                            state_reg   <= S_REQ;
                            addr_reg    <= {ALUResult[31:2], 2'b00};
                            addr_lo_reg <= ALUResult[1:0];
                            f3_reg      <= funct3;
                            we_reg      <= MemWrite;
                            be_reg      <= MemWrite ? store_be(funct3, ALUResult[1:0]) : BE_NONE;
                            wdata_reg   <= MemWrite ? store_wdata(funct3, ReadData2) : '0;
                            wait_reg    <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (MemReady) begin
                        state_reg     <= S_RESP;
                        fault_reg     <= 1'b0;
                        load_data_reg <= we_reg ? '0 : ext_data;
                    end else if (wait_hit) begin
                        state_reg     <= S_RESP;
                        fault_reg     <= 1'b1;
                        load_data_reg <= '0;
                    end else begin
                        wait_reg <= wait_inc;
                    end
                end
                S_RESP: begin
                    state_reg <= S_IDLE;
                    fault_reg <= 1'b0;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Gated by rst_n so the core is released the moment reset is asserted.
    assign Stall    = rst_n & (((state_reg == S_IDLE) & access) | (state_reg == S_REQ));
    assign Done     = (state_reg == S_RESP);
    assign Fault    = fault_reg;
    assign LoadData = load_data_reg;
    assign MemReq   = (state_reg == S_REQ);
    assign MemWe    = we_reg;
    assign MemAddr  = addr_reg;
    assign MemWData = wdata_reg;
    assign MemBe    = be_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of accesses with a Done scoreboard, plus
// hand-written timeout and mid-request reset sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite, MemReady;
    logic [2:0]  funct3;
    logic [31:0] ALUResult, ReadData2, MemRData;
    logic        Stall, Done, Fault, MemReq, MemWe;
    logic [31:0] LoadData, MemAddr, MemWData;
    logic [3:0]  MemBe;

    logic        rd_t, wr_t, ready_t;
    logic        Stall_t, Done_t, Fault_t, MemReq_t, MemWe_t;
    logic [31:0] LoadData_t, MemAddr_t, MemWData_t;
    logic [3:0]  MemBe_t;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .ALUResult(ALUResult), .ReadData2(ReadData2),
        .Stall(Stall), .Done(Done), .Fault(Fault), .LoadData(LoadData),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemBe(MemBe), .MemReady(MemReady), .MemRData(MemRData)
    );

    mem_access_unit #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .MemRead(rd_t), .MemWrite(wr_t),
        .funct3(funct3), .ALUResult(ALUResult), .ReadData2(ReadData2),
        .Stall(Stall_t), .Done(Done_t), .Fault(Fault_t), .LoadData(LoadData_t),
        .MemReq(MemReq_t), .MemWe(MemWe_t), .MemAddr(MemAddr_t), .MemWData(MemWData_t),
        .MemBe(MemBe_t), .MemReady(ready_t), .MemRData(MemRData)
    );

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, rs2, rdata;
        int          delay;
        logic        req;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_fault;
        logic [31:0] e_load;
        int          cycles;
    } vec_t;

    vec_t vecs[16];
    vec_t sb_q[$];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] rs2,
                                input logic [31:0] rdata, input int delay, input logic req,
                                input logic [31:0] e_addr, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic [31:0] e_load);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
        v.delay = delay; v.req = req; v.e_addr = e_addr; v.e_be = e_be;
        v.e_wdata = e_wdata; v.e_fault = ~req; v.e_load = e_load;
        v.cycles = req ? 3 + delay : 2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        vec_t e;
        int   req_cnt;
        logic saw_req;
        v = vecs[idx];
        MemRead = v.rd; MemWrite = v.wr; funct3 = v.f3; ALUResult = v.addr;
        ReadData2 = v.rs2; MemRData = v.rdata; MemReady = 1'b0;
        sb_q.push_back(v);
        req_cnt = 0;
        saw_req = 1'b0;
        for (int c = 1; c <= v.cycles; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d stall c%0d", idx, c), 32'(Stall), 32'(c < v.cycles));
            chk($sformatf("v%0d done c%0d", idx, c), 32'(Done), 32'(c == v.cycles));
            chk($sformatf("v%0d memreq c%0d", idx, c), 32'(MemReq),
                32'(v.req && c >= 2 && c < v.cycles));
            if (MemReq) begin
                if (!saw_req) begin
                    chk($sformatf("v%0d addr", idx), MemAddr, v.e_addr);
                    chk($sformatf("v%0d be", idx), 32'(MemBe), 32'(v.e_be));
                    chk($sformatf("v%0d we", idx), 32'(MemWe), 32'(v.wr));
                    if (v.wr) chk($sformatf("v%0d wdata", idx), MemWData, v.e_wdata);
                end else begin
                    chk($sformatf("v%0d addr stable c%0d", idx, c), MemAddr, v.e_addr);
                end
                saw_req = 1'b1;
                MemReady = (req_cnt == v.delay);
                req_cnt++;
            end else begin
                MemReady = 1'b0;
            end
            if (Done) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("v%0d unexpected done", idx), 32'(Done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("v%0d fault", idx), 32'(Fault), 32'(e.e_fault));
                    chk($sformatf("v%0d loaddata", idx), LoadData, e.e_load);
                end
            end
            @(posedge clk); #1;
        end
        MemRead = 1'b0; MemWrite = 1'b0; MemReady = 1'b0;
        $display("vector %0d: rd=%0b wr=%0b f3=%03b addr=%h -> fault=%0b load=%h",
                 idx, v.rd, v.wr, v.f3, v.addr, v.e_fault, v.e_load);
        if (sb_q.size() != 0) begin
            chk($sformatf("v%0d missing done", idx), 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rd wr f3 addr rs2 rdata delay req | e_addr e_be e_wdata e_load
        vecs[0]  = mk(0, 1, 3'b010, 32'h1004, 32'hDEADBEEF, 32'h0, 0, 1, 32'h1004, 4'b1111, 32'hDEADBEEF, 32'h0);
        vecs[1]  = mk(1, 0, 3'b000, 32'h2003, 32'h0, 32'h80FF1234, 0, 1, 32'h2000, 4'b0000, 32'h0, 32'hFFFFFF80);
        vecs[2]  = mk(1, 0, 3'b100, 32'h2003, 32'h0, 32'h80FF1234, 0, 1, 32'h2000, 4'b0000, 32'h0, 32'h00000080);
        vecs[3]  = mk(0, 1, 3'b001, 32'h3002, 32'h0000ABCD, 32'h0, 0, 1, 32'h3000, 4'b1100, 32'hABCDABCD, 32'h0);
        vecs[4]  = mk(1, 0, 3'b001, 32'h3001, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0);
        vecs[5]  = mk(1, 0, 3'b010, 32'h4008, 32'h0, 32'h12345678, 4, 1, 32'h4008, 4'b0000, 32'h0, 32'h12345678);
        vecs[6]  = mk(1, 0, 3'b001, 32'h2002, 32'h0, 32'h80FF1234, 0, 1, 32'h2000, 4'b0000, 32'h0, 32'hFFFF80FF);
        vecs[7]  = mk(1, 0, 3'b101, 32'h2000, 32'h0, 32'h80FF1234, 0, 1, 32'h2000, 4'b0000, 32'h0, 32'h00001234);
        vecs[8]  = mk(0, 1, 3'b000, 32'h5001, 32'h123456A7, 32'h0, 0, 1, 32'h5000, 4'b0010, 32'hA7A7A7A7, 32'h0);
        vecs[9]  = mk(1, 0, 3'b010, 32'h6002, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0);
        vecs[10] = mk(0, 1, 3'b100, 32'h6000, 32'h55, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0);
        vecs[11] = mk(1, 0, 3'b011, 32'h6000, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0);
        vecs[12] = mk(1, 1, 3'b010, 32'h6000, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0);
        vecs[13] = mk(1, 0, 3'b000, 32'h2000, 32'h0, 32'h80FF1234, 0, 1, 32'h2000, 4'b0000, 32'h0, 32'h00000034);
        vecs[14] = mk(1, 0, 3'b010, 32'h7000, 32'h0, 32'hCAFEF00D, 1, 1, 32'h7000, 4'b0000, 32'h0, 32'hCAFEF00D);
        vecs[15] = mk(1, 0, 3'b010, 32'h0020, 32'h0, 32'h0BADF00D, 0, 1, 32'h0020, 4'b0000, 32'h0, 32'h0BADF00D);

        rst_n = 1'b0;
        MemRead = 0; MemWrite = 0; MemReady = 0; funct3 = 3'b0;
        ALUResult = 0; ReadData2 = 0; MemRData = 0;
        rd_t = 0; wr_t = 0; ready_t = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset stall", 32'(Stall), 32'd0);
        chk("reset done", 32'(Done), 32'd0);
        chk("reset memreq", 32'(MemReq), 32'd0);
        chk("reset membe", 32'(MemBe), 32'd0);
        chk("reset memaddr", MemAddr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back: each vector starts in the IDLE cycle right after the previous RESP.
        for (int i = 0; i < 15; i++) run_vec(i);

        // Timeout on the TIMEOUT=4 instance: REQ in cycles 2..5, Done+Fault in cycle 6.
        rd_t = 1'b1; funct3 = 3'b010; ALUResult = 32'h40; ready_t = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("timeout memreq c%0d", c), 32'(MemReq_t), 32'(c >= 2 && c <= 5));
            chk($sformatf("timeout stall c%0d", c), 32'(Stall_t), 32'(c <= 5));
            chk($sformatf("timeout done c%0d", c), 32'(Done_t), 32'(c == 6));
            if (c == 6) begin
                chk("timeout fault", 32'(Fault_t), 32'd1);
                chk("timeout loaddata", LoadData_t, 32'd0);
            end
            @(posedge clk); #1;
        end
        rd_t = 1'b0;
        @(negedge clk);
        chk("timeout back to idle", 32'(MemReq_t | Done_t), 32'd0);
        $display("timeout sequence: TIMEOUT=4 lw at 0x40 with no MemReady");
        @(posedge clk); #1;

        // Reset asserted while a lw sits in REQ.
        MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h10; MemReady = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst seq memreq before", 32'(MemReq), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst seq memreq", 32'(MemReq), 32'd0);
        chk("rst seq stall", 32'(Stall), 32'd0);
        MemRead = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst seq no done", 32'(Done), 32'd0);
        chk("rst seq loaddata", LoadData, 32'd0);
        chk("rst seq memaddr", MemAddr, 32'd0);
        chk("rst seq memwe", 32'(MemWe), 32'd0);
        chk("rst seq fault", 32'(Fault), 32'd0);
        rst_n = 1'b1;
        $display("reset sequence: rst_n pulled low during REQ of lw at 0x10");
        @(posedge clk); #1;
        run_vec(15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store unit directly downstream of the ALU. It takes the ALU's computed effective address (ALUResult) and the store operand (ReadData2), drives a ready-handshaked word-wide data-memory/MMIO port, and returns the sign- or zero-extended load value. It also raises Stall so the core holds PC and all instruction-derived inputs stable while an access is outstanding. Misaligned, illegal and timed-out accesses complete with Fault instead of touching memory.

## Interface
- TIMEOUT, 255: maximum REQ-state cycles without MemReady before a timeout fault (1..65535).
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- MemRead  in  1  current instruction is a load.
- MemWrite  in  1  current instruction is a store.
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- ALUResult  in  32  effective byte address.
- ReadData2  in  32  store data (rs2).
- Stall  out  1  core must not advance; combinational.
- Done  out  1  one-cycle completion pulse.
- Fault  out  1  valid with Done: access misaligned, illegal, or timed out.
- LoadData  out  32  extended load result, valid with Done; 0 for stores and faults.
- MemReq  out  1  memory request, held until accepted.
- MemWe  out  1  1 = write, 0 = read; valid with MemReq.
- MemAddr  out  32  word address, ALUResult with bits [1:0] cleared.
- MemWData  out  32  lane-replicated store data.
- MemBe  out  4  byte enables; 0000 on reads.
- MemReady  in  1  memory accepts/completes the request this cycle.
- MemRData  in  32  read word, valid when MemReady is high on a read.

## Operation
- States: IDLE, REQ, RESP.
- In IDLE, when MemRead or MemWrite is high:
  - Legal access: latch address, funct3 and data into the request registers; go to REQ.
  - Fault condition: go straight to RESP with Fault=1; no MemReq is issued.
- Fault conditions:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠00.
  - funct3 not in {000,001,010,100,101}.
  - Store with funct3 100 or 101.
  - MemRead and MemWrite both high.
- REQ:
  - MemReq=1. MemWe, MemAddr, MemWData and MemBe are registered and held stable.
  - MemReady=1: capture MemRData (reads) and go to RESP.
  - No MemReady: increment the wait counter. When the counter reaches TIMEOUT, deassert MemReq, go to RESP with Fault=1.
- RESP: Done=1, Stall=0, Fault and LoadData driven from registers; always returns to IDLE next cycle.
- Stall = (IDLE && (MemRead || MemWrite)) || REQ. It is low in RESP, so the core advances at the edge that ends the Done cycle and the same instruction is never re-triggered.
- Store lanes:
  - sb: MemBe = 1 << addr[1:0], MemWData = {4{rs2[7:0]}}.
  - sh: MemBe = addr[1] ? 1100 : 0011, MemWData = {2{rs2[15:0]}}.
  - sw: MemBe = 1111, MemWData = rs2.
- Load extract: select the byte or halfword lane by addr[1:0], then sign-extend (b, h) or zero-extend (bu, hu); w passes through unchanged.
- MemReady is ignored outside REQ.

## Timing
- Reset (asynchronous, immediate): state IDLE, wait counter 0; Done, Fault, MemReq, MemWe = 0; LoadData, MemAddr, MemWData = 0; MemBe = 0000.
- Reset mid-REQ drops MemReq at once, and no Done is produced.
- Minimum legal access is 3 cycles: IDLE (Stall=1), then REQ with MemReady=1, then RESP (Done).
- Each REQ cycle without MemReady adds 1 cycle.
- A fault detected in IDLE completes in 2 cycles.
- Timeout completes TIMEOUT+2 cycles after the access is detected.
- Wait counter is 16 bits and saturates; it is cleared on REQ entry.
- Back-to-back memory instructions: the next access may be detected in the IDLE cycle immediately after RESP.

## Structure
- Shared package/header mem_access_pkg:
  - funct3 size codes, state encodings, and the MemBe patterns.
  - These same funct3 constants serve the decoder and the ALU.
- Sub-module load_extend: combinational; takes MemRData, addr[1:0] and funct3 and produces the 32-bit extended value. It is instantiated once, before the LoadData register.

## Test plan
- sw: ALUResult=0x1004, rs2=0xDEADBEEF, MemReady high in the first REQ cycle → MemAddr=0x1004, MemBe=1111, MemWe=1, Done in cycle 3, Fault=0.
- lb / lbu: addr=0x2003, MemRData=0x80FF_1234 → lb gives LoadData=0xFFFFFF80, lbu gives 0x00000080, MemBe=0000.
- sh: addr=0x3002, rs2=0x0000ABCD → MemBe=1100, MemWData=0xABCDABCD; lh at 0x3001 → Fault=1 after 2 cycles with no MemReq.
- Slow memory: MemReady asserted 5 cycles into REQ → Stall high for 6 cycles, MemAddr stable throughout, Done on cycle 7.
- Timeout: TIMEOUT=4, MemReady never asserted → MemReq drops after 4 REQ cycles, Done with Fault=1, LoadData=0.
- Reset: rst_n pulled low during REQ → MemReq=0 and Stall=0 immediately; after release the unit is IDLE and a new lw completes normally.
